// File: rtl/mmio_io_ctrl.sv
// Memory-mapped I/O controller: decodes the 0xC000 window, gates BRAM writes and
// provides per-channel LED, debounced switch, sticky edge and interrupt-mask registers.
module mmio_io_ctrl #(
   parameter int WIDTH  = 16,
   parameter int NCH    = 2,
   parameter int IN_W   = 8,
   parameter int OUT_W  = 8,
   parameter int DB_CYC = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [WIDTH-1:0]     cpu_addr_i,
   input  logic [WIDTH-1:0]     cpu_wdata_i,
   input  logic                 cpu_we_i,
   input  logic [WIDTH-1:0]     mem_q_i,
   output logic                 mem_we_o,
   output logic [WIDTH-1:0]     cpu_rdata_o,
   input  logic [NCH*IN_W-1:0]  sw_i,
   output logic [NCH*OUT_W-1:0] led_o,
   output logic                 irq_o
);

   logic [1:0] rst_sync_q;
   logic       rst_int_n;

   // Reset asserts immediately but is released two clock edges later, aligned to clk_i.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rst_sync_q <= 2'b00;
      else         rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_int_n = rst_sync_q[1];

   logic       io_sel;
   logic       io_wr;
   logic [1:0] reg_sel;
   logic [2:0] ch_idx;
   logic       unused_bits;

   assign io_sel      = (cpu_addr_i[WIDTH-1 -: 2] == 2'b11);
   assign io_wr       = cpu_we_i & io_sel;
   assign reg_sel     = cpu_addr_i[1:0];
   assign ch_idx      = cpu_addr_i[4:2];
   assign mem_we_o    = cpu_we_i & ~io_sel;
   assign unused_bits = ^{cpu_addr_i, cpu_wdata_i};

   logic [NCH-1:0][WIDTH-1:0] ch_rdata;
   logic [NCH-1:0]            ch_irq;

   for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic [IN_W-1:0]  sync1_q;
      logic [IN_W-1:0]  db_q;
      logic [IN_W-1:0]  db_d;
      logic [IN_W-1:0]  edge_q;
      logic [IN_W-1:0]  edge_d;
      logic [IN_W-1:0]  edge_clr;
      logic [IN_W-1:0]  mask_q;
      logic [OUT_W-1:0] led_q;
      logic             wr_en;
      logic [WIDTH-1:0] rd_val;

      assign wr_en = io_wr & (ch_idx == 3'(gi));

      if (DB_CYC == 0) begin : g_bypass
         // The debounced register doubles as the second synchronizer stage.
         assign db_d = sync1_q;
      end else begin : g_db
         localparam int CW = $clog2(DB_CYC + 2);
         logic [IN_W-1:0] sync2_q;
         logic [IN_W-1:0] prev_q;
         logic [CW-1:0]   cnt_q;
         logic [CW-1:0]   stable_cnt;

         // Number of consecutive cycles, including this one, that sync2_q has held.
         assign stable_cnt = (sync2_q != prev_q) ? CW'(1) : cnt_q + CW'(1);
         assign db_d       = (stable_cnt >= CW'(DB_CYC)) ? sync2_q : db_q;

         always_ff @(posedge clk_i or negedge rst_int_n) begin
            if (!rst_int_n) begin
               sync2_q <= '0;
               prev_q  <= '0;
               cnt_q   <= '0;
            end else begin
               sync2_q <= sync1_q;
               prev_q  <= sync2_q;
               cnt_q   <= (stable_cnt >= CW'(DB_CYC)) ? CW'(DB_CYC) : stable_cnt;
            end
         end
      end

      assign edge_clr = (wr_en && reg_sel == 2'd2) ? cpu_wdata_i[IN_W-1:0] : '0;
      assign edge_d   = (edge_q & ~edge_clr) | (db_d & ~db_q);

      always_ff @(posedge clk_i or negedge rst_int_n) begin
         if (!rst_int_n) begin
            sync1_q <= '0;
            db_q    <= '0;
            edge_q  <= '0;
            mask_q  <= '0;
            led_q   <= '0;
         end else begin
            sync1_q <= sw_i[gi*IN_W +: IN_W];
            db_q    <= db_d;
            edge_q  <= edge_d;
            if (wr_en && reg_sel == 2'd0) led_q  <= cpu_wdata_i[OUT_W-1:0];
            if (wr_en && reg_sel == 2'd3) mask_q <= cpu_wdata_i[IN_W-1:0];
         end
      end

      always_comb begin
         rd_val = '0;
         case (reg_sel)
            2'd0:    rd_val[OUT_W-1:0] = led_q;
            2'd1:    rd_val[IN_W-1:0]  = db_q;
            2'd2:    rd_val[IN_W-1:0]  = edge_q;
            default: rd_val[IN_W-1:0]  = mask_q;
         endcase
      end

      assign ch_rdata[gi]                = rd_val;
      assign ch_irq[gi]                  = |(edge_q & mask_q);
      assign led_o[gi*OUT_W +: OUT_W]    = led_q;
   end

   logic [WIDTH-1:0] io_rdata;

   // Channel indices beyond NCH fall through to zero.
   always_comb begin
      io_rdata = '0;
      for (int c = 0; c < NCH; c++) begin
         if (ch_idx == 3'(c)) io_rdata = ch_rdata[c];
      end
   end

   assign cpu_rdata_o = io_sel ? io_rdata : mem_q_i;

   logic irq_q;

   always_ff @(posedge clk_i or negedge rst_int_n) begin
      if (!rst_int_n) irq_q <= 1'b0;
      else            irq_q <= |ch_irq;
   end
   assign irq_o = irq_q;

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Directed and randomized bench for mmio_io_ctrl against a history-window reference model.
module tb_mmio_io_ctrl;

   localparam int W     = 16;
   localparam int NCH   = 2;
   localparam int IN_W  = 8;
   localparam int OUT_W = 8;
   localparam int DB    = 4;

   logic                 clk;
   logic                 rst_n;
   logic [W-1:0]         addr;
   logic [W-1:0]         wdata;
   logic                 we;
   logic [W-1:0]         mem_q;
   logic                 mem_we;
   logic [W-1:0]         rdata;
   logic [NCH*IN_W-1:0]  sw;
   logic [NCH*OUT_W-1:0] led;
   logic                 irq;

   int nvec = 0;
   int nerr = 0;

   mmio_io_ctrl #(
      .WIDTH(W), .NCH(NCH), .IN_W(IN_W), .OUT_W(OUT_W), .DB_CYC(DB)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .cpu_addr_i(addr), .cpu_wdata_i(wdata),
      .cpu_we_i(we), .mem_q_i(mem_q), .mem_we_o(mem_we), .cpu_rdata_o(rdata),
      .sw_i(sw), .led_o(led), .irq_o(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: debounced value follows the pin once the pin samples taken
   // 2..DB+1 edges ago all agree.
   logic [7:0] m_led  [NCH];
   logic [7:0] m_mask [NCH];
   logic [7:0] m_edge [NCH];
   logic [7:0] m_db   [NCH];
   logic [7:0] m_hist [NCH][DB+2];
   logic       m_irq;
   int         m_rel;

   task automatic model_clear();
      for (int c = 0; c < NCH; c++) begin
         m_led[c] = 0; m_mask[c] = 0; m_edge[c] = 0; m_db[c] = 0;
         for (int k = 0; k < DB + 2; k++) m_hist[c][k] = 0;
      end
      m_irq = 0;
   endtask

   task automatic model_async_reset();
      model_clear();
      m_rel = 0;
   endtask

   task automatic model_edge();
      logic       irq_new;
      logic       io;
      logic       wr;
      logic       all_eq;
      logic [7:0] clr;
      logic [7:0] db_new;
      if (!rst_n || m_rel < 2) begin
         model_clear();
         if (rst_n) m_rel++;
         return;
      end
      irq_new = 0;
      for (int c = 0; c < NCH; c++) irq_new |= |(m_edge[c] & m_mask[c]);
      io = (addr[15:14] == 2'b11);
      for (int c = 0; c < NCH; c++) begin
         for (int k = DB + 1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
         m_hist[c][0] = sw[c*IN_W +: IN_W];
         all_eq = 1;
         for (int k = 3; k <= DB + 1; k++) if (m_hist[c][k] != m_hist[c][2]) all_eq = 0;
         db_new = all_eq ? m_hist[c][2] : m_db[c];
         wr  = we && io && (int'(addr[4:2]) == c);
         clr = (wr && addr[1:0] == 2'd2) ? wdata[7:0] : 8'h00;
         m_edge[c] = (m_edge[c] & ~clr) | (db_new & ~m_db[c]);
         if (wr && addr[1:0] == 2'd0) m_led[c]  = wdata[7:0];
         if (wr && addr[1:0] == 2'd3) m_mask[c] = wdata[7:0];
         m_db[c] = db_new;
      end
      m_irq = irq_new;
   endtask

   function automatic logic [15:0] exp_rdata();
      int c;
      c = int'(addr[4:2]);
      if (addr[15:14] != 2'b11) return mem_q;
      if (c >= NCH) return 16'h0;
      case (addr[1:0])
         2'd0:    return {8'h00, m_led[c]};
         2'd1:    return {8'h00, m_db[c]};
         2'd2:    return {8'h00, m_edge[c]};
         default: return {8'h00, m_mask[c]};
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Check outputs at the falling edge, then advance the model on the rising edge.
   task automatic cyc();
      @(negedge clk);
      chk("rdata", 32'(rdata), 32'(exp_rdata()));
      chk("mem_we", 32'(mem_we), 32'(we & (addr[15:14] != 2'b11)));
      chk("led", 32'(led), 32'({m_led[1], m_led[0]}));
      chk("irq", 32'(irq), 32'(m_irq));
      @(posedge clk);
      model_edge();
      #1;
   endtask

   initial begin
      rst_n = 0; we = 0; addr = 16'h0; wdata = 16'h0; mem_q = 16'h1234; sw = 16'h00FF;
      model_async_reset();

      // Reset behaviour
      repeat (3) cyc();
      addr = 16'hC001; #1;
      chk("t1_led", 32'(led), 32'h0);
      chk("t1_irq", 32'(irq), 32'h0);
      chk("t1_in", 32'(rdata), 32'h0);
      rst_n = 1; sw = 16'h0000;
      repeat (10) cyc();

      // LED store, RAM store, readback
      addr = 16'hC000; wdata = 16'h00A5; we = 1; #1;
      chk("t2_memwe_io", 32'(mem_we), 32'h0);
      cyc(); we = 0;
      chk("t2_led", 32'(led[7:0]), 32'hA5);
      addr = 16'h0010; wdata = 16'h5A5A; we = 1; #1;
      chk("t2_memwe_ram", 32'(mem_we), 32'h1);
      cyc(); we = 0;
      chk("t2_led_keep", 32'(led[7:0]), 32'hA5);
      addr = 16'hC000; #1;
      chk("t2_rd_led", 32'(rdata), 32'h00A5);
      addr = 16'h0010; mem_q = 16'hBEEF; #1;
      chk("t2_rd_ram", 32'(rdata), 32'hBEEF);

      // Debounce latency and glitch rejection on ch1
      addr = 16'hC005; sw[15:8] = 8'h03;
      for (int i = 1; i <= 6; i++) begin
         cyc();
         chk("t3_in_latency", 32'(rdata), (i == 6) ? 32'h3 : 32'h0);
      end
      sw[15:8] = 8'h07;
      repeat (3) cyc();
      sw[15:8] = 8'h03;
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk("t3_glitch", 32'(rdata), 32'h3);
      end

      // Edge flag, mask, irq, clear and set-wins
      addr = 16'hC003; wdata = 16'h0001; we = 1;
      cyc(); we = 0;
      addr = 16'hC002; sw[7:0] = 8'h01;
      for (int i = 1; i <= 7; i++) begin
         cyc();
         chk("t4_edge", 32'(rdata), (i >= 6) ? 32'h1 : 32'h0);
         chk("t4_irq", 32'(irq), (i >= 7) ? 32'h1 : 32'h0);
      end
      wdata = 16'h0001; we = 1;
      cyc(); we = 0;
      chk("t4_clr_edge", 32'(rdata), 32'h0);
      chk("t4_clr_irq_lag", 32'(irq), 32'h1);
      cyc();
      chk("t4_clr_irq", 32'(irq), 32'h0);
      sw[7:0] = 8'h03;
      repeat (5) cyc();
      wdata = 16'h0002; we = 1;
      cyc(); we = 0;
      chk("t4_set_wins", 32'(rdata), 32'h2);

      // Out-of-range channel
      addr = 16'hC014; #1;
      chk("t5_rd", 32'(rdata), 32'h0);
      wdata = 16'hFFFF; we = 1; #1;
      chk("t5_memwe", 32'(mem_we), 32'h0);
      cyc(); we = 0;
      chk("t5_led", 32'(led), 32'h00A5);
      addr = 16'hC003; #1;
      chk("t5_mask", 32'(rdata), 32'h1);

      // Reset in the middle of a debounce
      sw[7:0] = 8'h00;
      repeat (10) cyc();
      addr = 16'hC001; sw[7:0] = 8'h01;
      repeat (3) cyc();
      rst_n = 0; model_async_reset(); #1;
      chk("t6_in_rst", 32'(rdata), 32'h0);
      repeat (2) cyc();
      rst_n = 1;
      for (int i = 1; i <= 8; i++) begin
         cyc();
         chk("t6_in_restart", 32'(rdata), (i == 8) ? 32'h1 : 32'h0);
      end

      // Randomized traffic
      for (int n = 0; n < 2500; n++) begin
         for (int c = 0; c < NCH; c++) begin
            if ($urandom_range(0, 5) == 0) begin
               if ($urandom_range(0, 3) == 0) sw[c*IN_W +: IN_W] = 8'($urandom);
               else sw[c*IN_W +: IN_W] = sw[c*IN_W +: IN_W] ^ (8'h1 << $urandom_range(0, 7));
            end
         end
         addr = 16'($urandom);
         if ($urandom_range(0, 9) < 7) addr[15:14] = 2'b11;
         if ($urandom_range(0, 3) != 0) addr[4:2] = 3'($urandom_range(0, 1));
         we    = ($urandom_range(0, 2) == 0);
         wdata = 16'($urandom);
         mem_q = 16'($urandom);
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
